// File: rtl/branch_con_unit.sv
// rtl/branch_con_unit.sv - registered branch-condition evaluator with CON flip-flop and statistics
//
// Purpose:
//   Decodes the 3-bit condition field of the IR and evaluates it against the bus.
//   Single-operand conditions resolve one cycle after con_in. Two-operand conditions
//   (eq, signed lt) capture operand A with con_in, then wait for b_valid to supply B.
//   The result is held in the CON flop; saturating counters track evaluations and takens.
//
// Ports:
//   clk          in   1        rising-edge clock
//   reset_n      in   1        synchronous active-low reset
//   ir           in   IR_W     instruction register; cond = ir[COND_LSB+2:COND_LSB]
//   bus          in   DATA_W   datapath bus, operand source
//   con_in       in   1        start evaluation of the current cond
//   b_valid      in   1        bus holds operand B (only while busy)
//   cnt_clr      in   1        synchronous clear of statistics counters
//   con          out  1        branch-taken flag
//   con_valid    out  1        one-cycle pulse when con was updated
//   busy         out  1        waiting for operand B
//   eval_count   out  CNT_W    completed evaluations, saturating
//   taken_count  out  CNT_W    evaluations with con=1, saturating

module branch_con_unit #(
    parameter int DATA_W   = 32,
    parameter int IR_W     = 32,
    parameter int COND_LSB = 19,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IR_W-1:0]   ir,
    input  logic [DATA_W-1:0] bus,
    input  logic              con_in,
    input  logic              b_valid,
    input  logic              cnt_clr,
    output logic              con,
    output logic              con_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  eval_count,
    output logic [CNT_W-1:0]  taken_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        WAIT_B = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic                con_q, con_d;
    logic                con_valid_q, con_valid_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [2:0]          c_q, c_d;
    logic [CNT_W-1:0]    eval_q, eval_d;
    logic [CNT_W-1:0]    taken_q, taken_d;

    logic [2:0]          cond;
    logic                unused_ir;

    assign cond      = ir[COND_LSB+2:COND_LSB];
    // Only the cond field matters; the rest of the IR is deliberately ignored.
    assign unused_ir = ^ir;

    function automatic logic eval_single(input logic [2:0] c, input logic [DATA_W-1:0] v);
        logic r;
        r = 1'b0;
        case (c)
            3'b000:  r = (v == '0);
            3'b001:  r = (v != '0);
            3'b010:  r = ~v[DATA_W-1];
            3'b011:  r = v[DATA_W-1];
            3'b100:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // c[0] selects signed less-than (111) versus equality (110).
    function automatic logic eval_pair(input logic [2:0] c, input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
        logic r;
        if (c[0]) begin
            r = ($signed(a) < $signed(b));
        end else begin
            r = (a == b);
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        con_d       = con_q;
        con_valid_d = 1'b0;
        busy_d      = busy_q;
        a_d         = a_q;
        c_d         = c_q;
        eval_d      = eval_q;
        taken_d     = taken_q;

        case (state_q)
            IDLE: begin
                // b_valid is ignored here, including when coincident with con_in.
                if (con_in) begin
                    if (cond[2:1] == 2'b11) begin
                        a_d     = bus;
                        c_d     = cond;
                        busy_d  = 1'b1;
                        state_d = WAIT_B;
                    end else begin
                        con_d       = eval_single(cond, bus);
                        con_valid_d = 1'b1;
                    end
                end
            end
            WAIT_B: begin
                // con_in and ir are ignored while busy; the latched cond is used.
                if (b_valid) begin
                    con_d       = eval_pair(c_q, a_q, bus);
                    con_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Counters account for the result that is being presented on con this cycle.
        if (cnt_clr) begin
            eval_d  = '0;
            taken_d = '0;
        end else if (con_valid_q) begin
            if (eval_q != CNT_MAX) begin
                eval_d = eval_q + CNT_ONE;
            end
            if (con_q && (taken_q != CNT_MAX)) begin
                taken_d = taken_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            con_q       <= 1'b0;
            con_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            a_q         <= '0;
            c_q         <= '0;
            eval_q      <= '0;
            taken_q     <= '0;
        end else begin
            state_q     <= state_d;
            con_q       <= con_d;
            con_valid_q <= con_valid_d;
            busy_q      <= busy_d;
            a_q         <= a_d;
            c_q         <= c_d;
            eval_q      <= eval_d;
            taken_q     <= taken_d;
        end
    end

    assign con         = con_q;
    assign con_valid   = con_valid_q;
    assign busy        = busy_q;
    assign eval_count  = eval_q;
    assign taken_count = taken_q;

endmodule

// File: tb/tb_branch_con_unit.sv
// tb/tb_branch_con_unit.sv - self-checking bench for branch_con_unit

module tb_branch_con_unit;

    localparam int DW = 32;
    localparam int IW = 32;
    localparam int CL = 19;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [IW-1:0] ir = '0;
    logic [DW-1:0] bus = '0;
    logic          con_in = 1'b0;
    logic          b_valid = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          con, con_valid, busy;
    logic [CW-1:0] eval_count, taken_count;

    int errors = 0;
    int checks = 0;

    // Reference model: a pending-operand record plus counters as integers.
    logic          m_con = 1'b0;
    logic          m_valid = 1'b0;
    logic          m_pending = 1'b0;
    logic [DW-1:0] m_a = '0;
    logic [2:0]    m_c = '0;
    int            m_eval = 0;
    int            m_taken = 0;

    branch_con_unit #(
        .DATA_W(DW), .IR_W(IW), .COND_LSB(CL), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ir(ir), .bus(bus), .con_in(con_in),
        .b_valid(b_valid), .cnt_clr(cnt_clr), .con(con), .con_valid(con_valid),
        .busy(busy), .eval_count(eval_count), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    function automatic logic ref_eval(input logic [2:0] c, input logic [DW-1:0] a,
                                      input logic [DW-1:0] b);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (c)
            3'd0: return b == 0;
            3'd1: return b != 0;
            3'd2: return sb >= 0;
            3'd3: return sb < 0;
            3'd4: return 1'b1;
            3'd5: return 1'b0;
            3'd6: return a == b;
            default: return sa < sb;
        endcase
    endfunction

    function automatic logic [3+2*CW-1:0] exp_vec();
        return {m_con, m_valid, m_pending, CW'(m_eval), CW'(m_taken)};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, sample 1ns later.
    task automatic step(input logic [2:0] c, input logic [DW-1:0] b, input logic ci,
                        input logic bv, input logic clr, input logic rst);
        logic [IW-1:0] r;
        r = IW'($urandom);
        r[CL+2 -: 3] = c;
        ir = r; bus = b; con_in = ci; b_valid = bv; cnt_clr = clr; reset_n = rst;
        @(posedge clk);
        if (!rst) begin
            m_con = 0; m_valid = 0; m_pending = 0; m_a = '0; m_eval = 0; m_taken = 0;
        end else begin
            if (clr) begin
                m_eval = 0; m_taken = 0;
            end else if (m_valid) begin
                m_eval = (m_eval < CMAX) ? m_eval + 1 : CMAX;
                if (m_con) m_taken = (m_taken < CMAX) ? m_taken + 1 : CMAX;
            end
            m_valid = 0;
            if (m_pending) begin
                if (bv) begin
                    m_con = ref_eval(m_c, m_a, b); m_valid = 1; m_pending = 0;
                end
            end else if (ci) begin
                if (c >= 3'd6) begin
                    m_a = b; m_c = c; m_pending = 1;
                end else begin
                    m_con = ref_eval(c, '0, b); m_valid = 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(3'd0, '0, 1, 0, 0, 0);
        step(3'd0, '0, 1, 0, 0, 0);
        checks++;
        if ({con, con_valid, busy, eval_count, taken_count} !== '0) begin
            errors++;
            $display("FAIL reset: got %b required all zero",
                     {con, con_valid, busy, eval_count, taken_count});
        end
    endtask

    task automatic test_single();
        logic [2:0]    cs [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        logic [DW-1:0] bs [6] = '{32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0};
        logic          ex [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        step(3'd0, '0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(cs[i], bs[i], 1, 0, 0, 1);
            checks++;
            if (con !== ex[i] || con_valid !== 1'b1) begin
                errors++;
                $display("FAIL single c=%0d: con=%b valid=%b required con=%b valid=1",
                         cs[i], con, con_valid, ex[i]);
            end
            step(3'd0, '0, 0, 0, 0, 1);
            checks++;
            if ({con, con_valid, busy, eval_count, taken_count} !== exp_vec()) begin
                errors++;
                $display("FAIL single_hold c=%0d: got %b required %b", cs[i],
                         {con, con_valid, busy, eval_count, taken_count}, exp_vec());
            end
        end
    endtask

    task automatic test_two_operand();
        logic [2:0]    cs [3] = '{3'd7, 3'd6, 3'd6};
        logic [DW-1:0] as [3] = '{32'hFFFF_FFFF, 32'd5, 32'd5};
        logic [DW-1:0] bs [3] = '{32'd1, 32'd5, 32'd6};
        logic          ex [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step(cs[i], as[i], 1, 0, 0, 1);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (busy !== 1'b1 || con_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL two_op_busy %0d cyc %0d: busy=%b valid=%b required 1/0",
                             i, k, busy, con_valid);
                end
                if (k < 3) step(3'd0, 32'h0, 0, 0, 0, 1);
            end
            step(3'd0, bs[i], 0, 1, 0, 1);
            checks++;
            if (con !== ex[i] || con_valid !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL two_op %0d: con=%b valid=%b busy=%b required %b/1/0",
                         i, con, con_valid, busy, ex[i]);
            end
        end
    endtask

    task automatic test_wait_b_ignore();
        step(3'd6, 32'd7, 1, 0, 0, 1);
        step(3'd0, 32'd0, 1, 0, 0, 1);
        step(3'd5, 32'd0, 1, 0, 0, 1);
        checks++;
        if (con_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_ignore: valid=%b busy=%b required 0/1", con_valid, busy);
        end
        step(3'd5, 32'd7, 0, 1, 0, 1);
        checks++;
        if (con !== 1'b1 || con_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_latched_cond: con=%b valid=%b required 1/1", con, con_valid);
        end
        step(3'd0, 32'd0, 0, 1, 0, 1);
        step(3'd0, 32'd0, 0, 1, 0, 1);
        checks++;
        if (con !== 1'b1 || con_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bvalid_idle: con=%b valid=%b busy=%b required 1/0/0",
                     con, con_valid, busy);
        end
    endtask

    task automatic test_reset_mid_wait();
        step(3'd4, 32'd0, 1, 0, 0, 1);
        step(3'd7, 32'd3, 1, 0, 0, 1);
        step(3'd0, 32'd0, 0, 0, 0, 0);
        checks++;
        if (busy !== 1'b0 || con !== 1'b0 || con_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait: busy=%b con=%b valid=%b required 0/0/0",
                     busy, con, con_valid);
        end
        step(3'd0, 32'd9, 0, 1, 0, 1);
        checks++;
        if (con_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_bvalid: valid=%b busy=%b required 0/0", con_valid, busy);
        end
    endtask

    task automatic test_saturation();
        step(3'd0, '0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) step(3'd4, 32'(i), 1, 0, 0, 1);
        step(3'd0, '0, 0, 0, 0, 1);
        step(3'd0, '0, 0, 0, 0, 1);
        checks++;
        if (eval_count !== 4'd15 || taken_count !== 4'd15) begin
            errors++;
            $display("FAIL saturate: eval=%0d taken=%0d required 15/15", eval_count, taken_count);
        end
        step(3'd4, '0, 1, 0, 0, 1);
        step(3'd0, '0, 0, 0, 1, 1);
        step(3'd0, '0, 0, 0, 0, 1);
        checks++;
        if (eval_count !== 4'd0 || taken_count !== 4'd0 || con !== 1'b1) begin
            errors++;
            $display("FAIL clr_wins: eval=%0d taken=%0d con=%b required 0/0/1",
                     eval_count, taken_count, con);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] pool [4] = '{32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h5};
        logic [DW-1:0] b;
        for (int i = 0; i < 600; i++) begin
            b = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : DW'($urandom);
            step(3'($urandom_range(0, 7)), b, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 59) != 0));
            checks++;
            if ({con, con_valid, busy, eval_count, taken_count} !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d: got %b required %b", i,
                         {con, con_valid, busy, eval_count, taken_count}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_operand();
        test_wait_b_ignore();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
